tdc_frame_streamer: RTL and testbench
=====================================

// Module: tdc_frame_streamer
// PURPOSE
//  Downstream of the TDC core. Captures each merged measurement word on the core's
//  one-cycle done pulse and queues it in a sync FIFO. Drains the queue as framed
//  byte packets on a valid/ready stream that feeds the UART transmitter.
//  Absorbs bursts of hits while the serial link is slow; counts words it has to drop.
// PARAMETERS
//  DATA_W     24     width of measurement word (tie to `DIG_OUT)
//  DEPTH      16     FIFO entries, power of 2, >=2
//  SYNC_BYTE  8'hA5  frame header byte
// PORTS
//  clk          in   1       system clock (same domain as TDC clk0)
//  iRst_n       in   1       synchronous reset, active-low
//  iDone        in   1       measurement-complete pulse from TDC
//  iTDC         in   DATA_W  measurement word, valid when iDone=1
//  oByte        out  8       stream byte
//  oValid       out  1       oByte valid
//  iReady       in   1       sink accepts byte when oValid&&iReady
//  oEmpty       out  1       FIFO empty
//  oFull        out  1       FIFO full
//  oDropCnt     out  8       saturating count of dropped words
//  oOverflow    out  1       sticky, set on first drop
// BEHAVIOUR
//  - Reset (iRst_n=0 at clk edge): FIFO pointers/count=0, FSM=IDLE, oValid=0,
//    oByte=0, oEmpty=1, oFull=0, oDropCnt=0, oOverflow=0. Reset mid-frame aborts
//    the frame; no partial-frame resume.
//  - Write: iDone=1 stores iTDC if count<DEPTH, or if count==DEPTH and a pop occurs
//    the same cycle. Otherwise word dropped: oDropCnt+=1 (saturate at 255),
//    oOverflow<=1. Stored word visible to reader the cycle after write.
//  - NBYTES = ceil(DATA_W/8); word zero-extended to NBYTES*8 bits, sent MSB byte first.
//  - FSM: IDLE -> HDR -> DATA -> IDLE (SEQ inserted between HDR and DATA when enabled).
//    IDLE: if !empty, pop head into shift register, go HDR; oValid=1, oByte=SYNC_BYTE
//      on the next cycle (1-cycle pop-to-valid latency).
//    HDR: on handshake, load first data byte, go DATA.
//    DATA: byte index 0..NBYTES-1; on handshake advance; on last byte's handshake
//      go IDLE with oValid=0. Next frame's header appears >=1 cycle after (no
//      back-to-back frames; one idle cycle guaranteed).
//  - oValid held and oByte stable until handshake; iReady ignored when oValid=0.
//  - oEmpty/oFull registered, reflect count after this cycle's push/pop.
//  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
// CONFIGURATION
//  TDC_SEQNUM_EN defined: 8-bit sequence counter, reset 0, inserted as one byte
//    after header (state SEQ); increments per frame sent (wraps 255->0), and also
//    per dropped word so host detects gaps. Frame = 2+NBYTES bytes.
//  Not defined: no SEQ state, frame = 1+NBYTES bytes, no counter logic.
// STRUCTURE
//  - defines.v: `TDC_SYNC_BYTE, `TDC_NBYTES(w) ceil macro, FSM state encodings.
//  - Sub-module tdc_sync_fifo (DATA_W, DEPTH): push/pop/full/empty/count, no
//    fall-through; streamer owns drop logic and framing FSM.
// TESTING
//  1 Reset: hold iRst_n=0 3 cycles with iDone=1 -> oValid=0, oEmpty=1, oDropCnt=0.
//  2 Single word iTDC=24'h123456, iReady=1 -> bytes A5,12,34,56 on 4 consecutive
//    handshakes; then oValid=0, oEmpty=1.
//  3 Backpressure: iReady=0 for 10 cycles mid-frame -> oByte/oValid unchanged;
//    resumes at same byte index when iReady=1.
//  4 Overflow: iReady=0, 20 iDone pulses -> oFull=1 after 16, oDropCnt=4,
//    oOverflow=1; drained words are the first 16 in order.
//  5 Full + simultaneous pop and push -> write accepted, oDropCnt unchanged.
//  6 Reset asserted after 2nd byte of frame -> oValid=0 next cycle; next frame
//    starts with A5. With TDC_SEQNUM_EN: 3 words -> seq bytes 00,01,02.

Source files
------------

// File: rtl/tdc_frame_streamer_pkg.sv
// Shared types and constants for the TDC frame streamer: FSM state encoding,
// frame header byte and the byte-count helper used to size the data payload.
package tdc_frame_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_SEQ  = 2'd2,
    ST_DATA = 2'd3
  } state_t;

  localparam logic [7:0] TDC_SYNC_BYTE = 8'hA5;

  // Number of whole bytes needed to carry a w-bit word.
  function automatic int tdc_nbytes(input int w);
    return (w + 32'sd7) / 32'sd8;
  endfunction

endpackage

// File: rtl/tdc_sync_fifo.sv
// Synchronous FIFO without fall-through: a written word is readable the cycle
// after the write. Full/empty are registered and reflect this cycle's push/pop.
module tdc_sync_fifo
  import tdc_frame_streamer_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DATA_W-1:0]       din,
  output logic [DATA_W-1:0]       dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic [AW:0]       count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify push/pop; a full FIFO still accepts a push when it pops the same cycle.
  always_comb begin
    do_pop_s    = pop && (count_r != '0);
    do_push_s   = push && ((count_r != DEPTH_C) || do_pop_s);
    count_nxt_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (do_pop_s && !do_push_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign count = count_r;

endmodule

// File: rtl/tdc_frame_streamer.sv
// Queues TDC measurement words and streams them as framed byte packets.
// Define TDC_SEQNUM_EN to insert an 8-bit sequence byte after the header.
module tdc_frame_streamer
  import tdc_frame_streamer_pkg::*;
#(
  parameter int          DATA_W    = 24,
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = TDC_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              iRst_n,
  input  logic              iDone,
  input  logic [DATA_W-1:0] iTDC,
  output logic [7:0]        oByte,
  output logic              oValid,
  input  logic              iReady,
  output logic              oEmpty,
  output logic              oFull,
  output logic [7:0]        oDropCnt,
  output logic              oOverflow
);

  localparam int NBYTES = tdc_nbytes(DATA_W);
  localparam int SW     = NBYTES * 8;
  localparam int AW     = $clog2(DEPTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam logic [AW:0]      DEPTH_C  = (AW+1)'(DEPTH);

  state_t            state_r, state_nxt_s;
  logic [SW-1:0]     shreg_r, shreg_nxt_s;
  logic [IDX_W-1:0]  idx_r, idx_nxt_s;
  logic [7:0]        byte_r, byte_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [7:0]        drop_cnt_r;
  logic              overflow_r;
  logic              hs_s;
  logic              pop_s;
  logic              accept_s;
  logic              drop_s;
  logic [DATA_W-1:0] fifo_dout_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [AW:0]       fifo_count_s;
`ifdef TDC_SEQNUM_EN
  logic [7:0]        seq_r;
  logic              frame_done_s;
`endif

  tdc_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (iRst_n),
    .push  (accept_s),
    .pop   (pop_s),
    .din   (iTDC),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Framing FSM: next state, shift register and output byte/valid.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    idx_nxt_s   = idx_r;
    byte_nxt_s  = byte_r;
    valid_nxt_s = valid_r;
    pop_s       = 1'b0;
    hs_s        = valid_r && iReady;
`ifdef TDC_SEQNUM_EN
    frame_done_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          shreg_nxt_s = SW'(fifo_dout_s);
          byte_nxt_s  = SYNC_BYTE;
          valid_nxt_s = 1'b1;
          state_nxt_s = ST_HDR;
        end else begin
          valid_nxt_s = 1'b0;
        end
      end
      ST_HDR: begin
        if (hs_s) begin
`ifdef TDC_SEQNUM_EN
          byte_nxt_s  = seq_r;
          state_nxt_s = ST_SEQ;
`else
          byte_nxt_s  = shreg_r[SW-1 -: 8];
          shreg_nxt_s = shreg_r << 4'd8;
          idx_nxt_s   = '0;
          state_nxt_s = ST_DATA;
`endif
        end else begin
          state_nxt_s = ST_HDR;
        end
      end
      ST_SEQ: begin
        if (hs_s) begin
          byte_nxt_s  = shreg_r[SW-1 -: 8];
          shreg_nxt_s = shreg_r << 4'd8;
          idx_nxt_s   = '0;
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_SEQ;
        end
      end
      ST_DATA: begin
        if (hs_s) begin
          if (idx_r == LAST_IDX) begin
            valid_nxt_s = 1'b0;
            state_nxt_s = ST_IDLE;
`ifdef TDC_SEQNUM_EN
            frame_done_s = 1'b1;
`endif
          end else begin
            byte_nxt_s  = shreg_r[SW-1 -: 8];
            shreg_nxt_s = shreg_r << 4'd8;
            idx_nxt_s   = idx_r + IDX_W'(1);
          end
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // A full FIFO still takes the word when the FSM pops in the same cycle.
  always_comb begin
    accept_s = iDone && ((fifo_count_s < DEPTH_C) || pop_s);
    drop_s   = iDone && !accept_s;
  end

  // FSM registers and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state_r    <= ST_IDLE;
      shreg_r    <= '0;
      idx_r      <= '0;
      byte_r     <= 8'h00;
      valid_r    <= 1'b0;
      drop_cnt_r <= 8'h00;
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      shreg_r <= shreg_nxt_s;
      idx_r   <= idx_nxt_s;
      byte_r  <= byte_nxt_s;
      valid_r <= valid_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

`ifdef TDC_SEQNUM_EN
  // Sequence number advances per completed frame and per dropped word.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      seq_r <= 8'h00;
    end else begin
      seq_r <= seq_r + {7'd0, frame_done_s} + {7'd0, drop_s};
    end
  end
`endif

  assign oByte     = byte_r;
  assign oValid    = valid_r;
  assign oEmpty    = fifo_empty_s;
  assign oFull     = fifo_full_s;
  assign oDropCnt  = drop_cnt_r;
  assign oOverflow = overflow_r;

endmodule

// File: tb/tb_tdc_frame_streamer.sv
// Directed bench for tdc_frame_streamer: a per-cycle vector table for reset and
// a single frame, then hand-written backpressure, overflow, full-pop and reset sequences.
module tb_tdc_frame_streamer;

  logic        clk;
  logic        iRst_n;
  logic        iDone;
  logic [23:0] iTDC;
  logic [7:0]  oByte;
  logic        oValid;
  logic        iReady;
  logic        oEmpty;
  logic        oFull;
  logic [7:0]  oDropCnt;
  logic        oOverflow;

  int n_vec;
  int n_err;
  int seq_model;

  typedef struct {
    logic        rst_n;
    logic        done;
    logic [23:0] tdc;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_byte;
    logic        exp_empty;
    logic        exp_full;
    logic [7:0]  exp_drop;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  tdc_frame_streamer #(.DATA_W(24), .DEPTH(16), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .iRst_n    (iRst_n),
    .iDone     (iDone),
    .iTDC      (iTDC),
    .oByte     (oByte),
    .oValid    (oValid),
    .iReady    (iReady),
    .oEmpty    (oEmpty),
    .oFull     (oFull),
    .oDropCnt  (oDropCnt),
    .oOverflow (oOverflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    iDone = 1'b1;
    iTDC  = w;
    step();
    iDone = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input string name);
    int n;
    n = 0;
    iReady = 1'b1;
    while (!oValid && n < 40) begin
      step();
      n++;
    end
    if (!oValid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no valid byte within 40 cycles, expected %0h", name, exp);
    end else begin
      check(name, oByte, exp);
      step();
    end
    iReady = 1'b0;
  endtask

  task automatic recv_frame(input logic [23:0] w);
    recv_byte(8'hA5, "hdr");
`ifdef TDC_SEQNUM_EN
    recv_byte(8'(seq_model), "seq");
`endif
    for (int b = 0; b < 3; b++) recv_byte(w[23-8*b -: 8], "data");
    seq_model++;
    check("valid_after_frame", oValid, 1'b0);
  endtask

  initial begin
    clk = 1'b0; iRst_n = 1'b0; iDone = 1'b0; iTDC = 24'h0; iReady = 1'b0;
    n_vec = 0; n_err = 0; seq_model = 0;

    // rst done tdc ready | valid byte empty full drop ovf
    vecs.push_back('{1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 24'h123456, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 8'd0, 1'b0});
`ifdef TDC_SEQNUM_EN
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});
`endif
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 8'h56, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      iRst_n = vecs[i].rst_n;
      iDone  = vecs[i].done;
      iTDC   = vecs[i].tdc;
      iReady = vecs[i].ready;
      step();
      check("tbl_valid", oValid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check("tbl_byte", oByte, vecs[i].exp_byte);
      check("tbl_empty", oEmpty, vecs[i].exp_empty);
      check("tbl_full", oFull, vecs[i].exp_full);
      check("tbl_drop", oDropCnt, vecs[i].exp_drop);
      check("tbl_ovf", oOverflow, vecs[i].exp_ovf);
    end
    iDone = 1'b0; iReady = 1'b0;
    seq_model = 1;

    // Backpressure in the middle of a frame.
    push_word(24'hABCDEF);
    recv_byte(8'hA5, "bp_hdr");
`ifdef TDC_SEQNUM_EN
    recv_byte(8'(seq_model), "bp_seq");
`endif
    recv_byte(8'hAB, "bp_d0");
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_hold_valid", oValid, 1'b1);
      check("bp_hold_byte", oByte, 8'hCD);
    end
    recv_byte(8'hCD, "bp_d1");
    recv_byte(8'hEF, "bp_d2");
    seq_model++;
    check("bp_valid_after", oValid, 1'b0);

    // Overflow: one frame stalled in the header, then 20 pulses into the FIFO.
    push_word(24'h0000AA);
    step();
    check("ovf_stall_valid", oValid, 1'b1);
    for (int i = 0; i < 20; i++) begin
      iDone = 1'b1;
      iTDC  = 24'(i + 1);
      step();
      if (i == 14) check("ovf_not_full_15", oFull, 1'b0);
      if (i == 15) check("ovf_full_16", oFull, 1'b1);
      if (i == 15) check("ovf_nodrop_16", oDropCnt, 8'd0);
    end
    iDone = 1'b0;
    check("ovf_full", oFull, 1'b1);
    check("ovf_drop", oDropCnt, 8'd4);
    check("ovf_sticky", oOverflow, 1'b1);
    seq_model += 4;
    recv_frame(24'h0000AA);

    // Full FIFO: push in the same cycle the FSM pops the head.
    iDone = 1'b1;
    iTDC  = 24'h777777;
    step();
    iDone = 1'b0;
    check("fullpop_full", oFull, 1'b1);
    check("fullpop_drop", oDropCnt, 8'd4);
    check("fullpop_valid", oValid, 1'b1);
    for (int w = 1; w <= 16; w++) recv_frame(24'(w));
    recv_frame(24'h777777);
    step();
    check("drain_empty", oEmpty, 1'b1);
    check("drain_full", oFull, 1'b0);

    // Reset in the middle of a frame.
    push_word(24'h010203);
    recv_byte(8'hA5, "rst_hdr");
`ifdef TDC_SEQNUM_EN
    recv_byte(8'(seq_model), "rst_seq");
`else
    recv_byte(8'h01, "rst_d0");
`endif
    iRst_n = 1'b0;
    step();
    iRst_n = 1'b1;
    check("rst_valid", oValid, 1'b0);
    check("rst_empty", oEmpty, 1'b1);
    check("rst_drop", oDropCnt, 8'd0);
    check("rst_ovf", oOverflow, 1'b0);
    seq_model = 0;
    push_word(24'h445566);
    push_word(24'h778899);
    push_word(24'hAABBCC);
    recv_frame(24'h445566);
    recv_frame(24'h778899);
    recv_frame(24'hAABBCC);
    step();
    check("final_empty", oEmpty, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
